// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TXDATA / STATUS / DIV registers.
// Macro UART_TX_FIFO_EN selects a FIFO_DEPTH-entry TX FIFO instead of a single holding register.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter logic [15:0] DIV_RESET  = 16'd868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        sel,
    output logic        txd
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bitCnt_q;
    logic [15:0] divCnt_q;
    logic [15:0] curDiv_q;
    logic        txd_q;
    logic [15:0] div_q;
    logic [15:0] div_d;
    logic        overflow_q;
    logic        overflow_d;

    logic [31:0] offset;
    logic [1:0]  wordIdx;
    logic        wrTx;
    logic        wrStatus;
    logic        wrDiv;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        bitEnd;
    logic [7:0]  head;
    logic [7:0]  fifoCount;
    logic [31:0] status;
    logic        unusedBits;

    // Unsigned wrap-around also pushes addresses below BASE_ADDR out of the window.
    assign offset     = addr - BASE_ADDR;
    assign sel        = offset < 32'd12;
    assign wordIdx    = offset[3:2];
    assign wrTx       = sel && we && (wordIdx == 2'd0);
    assign wrStatus   = sel && we && (wordIdx == 2'd1);
    assign wrDiv      = sel && we && (wordIdx == 2'd2);
    assign unusedBits = ^wd[31:16];

    assign push   = wrTx && !full;
    assign bitEnd = divCnt_q == (curDiv_q - 16'd1);
    assign pop    = !empty && ((state_q == IDLE) || ((state_q == STOP) && bitEnd));
    assign status = {16'd0, fifoCount, 4'd0, overflow_q, empty, full, state_q != IDLE};
    assign txd    = txd_q;

    always_comb begin
        rd = 32'd0;
        if (sel) begin
            case (wordIdx)
                2'd1:    rd = status;
                2'd2:    rd = {16'd0, div_q};
                default: rd = 32'd0;
            endcase
        end
    end

    always_comb begin
        div_d      = div_q;
        overflow_d = overflow_q;
        if (wrDiv) begin
            div_d = (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
        end
        if (wrStatus && wd[3]) begin
            overflow_d = 1'b0;
        end
        if (wrTx && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= DIV_RESET;
            overflow_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wrPtr_q;
    logic [AW:0] rdPtr_q;
    logic [AW:0] fillLevel;

    // The extra MSB on each pointer distinguishes full from empty when the indices match.
    assign fillLevel = wrPtr_q - rdPtr_q;
    assign fifoCount = 8'(fillLevel);
    assign empty     = wrPtr_q == rdPtr_q;
    assign full      = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign head      = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q[AW-1:0]] <= wd[7:0];
        end
    end
`else
    localparam int unusedDepth = FIFO_DEPTH;

    logic [7:0] hold_q;
    logic       valid_q;

    assign full      = valid_q;
    assign empty     = !valid_q;
    assign head      = hold_q;
    assign fifoCount = {7'd0, valid_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            hold_q  <= 8'd0;
        end else if (push) begin
            valid_q <= 1'b1;
            hold_q  <= wd[7:0];
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end
`endif

    // The divisor is re-sampled at every bit boundary so a DIV write never stretches the current bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            txd_q    <= 1'b1;
            shift_q  <= 8'd0;
            bitCnt_q <= 3'd0;
            divCnt_q <= 16'd0;
            curDiv_q <= DIV_RESET;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        shift_q  <= head;
                        state_q  <= START;
                        txd_q    <= 1'b0;
                        divCnt_q <= 16'd0;
                        curDiv_q <= div_q;
                    end
                end
                START: begin
                    if (bitEnd) begin
                        state_q  <= DATA;
                        txd_q    <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                        bitCnt_q <= 3'd0;
                        divCnt_q <= 16'd0;
                        curDiv_q <= div_q;
                    end else begin
                        divCnt_q <= divCnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (bitEnd) begin
                        divCnt_q <= 16'd0;
                        curDiv_q <= div_q;
                        if (bitCnt_q == 3'd7) begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            txd_q    <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                            bitCnt_q <= bitCnt_q + 3'd1;
                        end
                    end else begin
                        divCnt_q <= divCnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (bitEnd) begin
                        divCnt_q <= 16'd0;
                        curDiv_q <= div_q;
                        if (!empty) begin
                            shift_q <= head;
                            state_q <= START;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                        end
                    end else begin
                        divCnt_q <= divCnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register-access vector table, a serial frame
// decoder feeding a byte scoreboard, and hand-written multi-cycle sequences.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_ST  = BASE + 32'h4;
    localparam logic [31:0] A_DIV = BASE + 32'h8;
    localparam logic [31:0] DIVR  = 32'd868;

`ifdef UART_TX_FIFO_EN
    localparam bit FIFO_MODE = 1'b1;
`else
    localparam bit FIFO_MODE = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [31:0] expRd;
        logic        expSel;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        sel;
    logic        txd;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] expQ [$];
    int         startQ [$];

    int         monDiv = 4;
    bit         monActive = 1'b0;
    bit         monGlitch;
    bit         monAbort;
    int         monStart;
    logic [9:0] monBits;

    mmio_uart_tx dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .wd   (wd),
        .rd   (rd),
        .sel  (sel),
        .txd  (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        addr = v.addr;
        we   = v.we;
        wd   = v.wd;
        #1;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
        wd   = 32'd0;
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d, output logic s);
        @(negedge clk);
        addr = a;
        we   = 1'b0;
        #1;
        d = rd;
        s = sel;
    endtask

    task automatic waitIdle(input int budget, output int idleCyc);
        logic [31:0] st;
        logic        s;
        int          n;
        n  = 0;
        st = 32'h1;
        while (st[0] && n < budget) begin
            busRead(A_ST, st, s);
            n++;
        end
        checks++;
        if (st[0]) begin
            failures++;
            $display("[TB] FAIL idleWait: busy still 1 after %0d cycles, expected 0", budget);
        end
        idleCyc = cyc;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || monActive) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expQ.size() != 0 || monActive) begin
            failures++;
            $display("[TB] FAIL drain: %0d bytes still pending after %0d cycles, expected 0", expQ.size(), budget);
        end
    endtask

    // Serial decoder: every bit is sampled DIV times and must stay constant; bytes go to the scoreboard.
    always begin
        @(negedge clk);
        if (!rst && txd === 1'b0) begin
            monActive = 1'b1;
            monStart  = cyc;
            monGlitch = 1'b0;
            monAbort  = 1'b0;
            monBits   = '0;
            for (int b = 0; b < 10 && !monAbort; b++) begin
                for (int c = 0; c < monDiv && !monAbort; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst) monAbort = 1'b1;
                    else if (c == 0) monBits[b] = txd;
                    else if (txd !== monBits[b]) monGlitch = 1'b1;
                end
            end
            if (!monAbort) begin
                startQ.push_back(monStart);
                checkOutput("bitDuration", 32'(monGlitch), 32'd0);
                checkOutput("stopBit", 32'(monBits[9]), 32'd1);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedFrame: got byte 0x%02h, expected no frame", monBits[8:1]);
                end else begin
                    checkOutput("frameData", 32'(monBits[8:1]), 32'(expQ.pop_front()));
                end
            end
            monActive = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [14];
        logic [31:0] st;
        logic        s;
        int          idleCyc;
        int          lowCnt;

        vecs[0]  = '{A_ST,                1'b0, 32'd0,          32'h4,      1'b1};
        vecs[1]  = '{A_DIV,               1'b0, 32'd0,          DIVR,       1'b1};
        vecs[2]  = '{A_TX,                1'b0, 32'd0,          32'h0,      1'b1};
        vecs[3]  = '{BASE + 32'hC,        1'b0, 32'd0,          32'h0,      1'b0};
        vecs[4]  = '{32'h0FFF_FFFC,       1'b0, 32'd0,          32'h0,      1'b0};
        vecs[5]  = '{A_DIV,               1'b1, 32'd0,          DIVR,       1'b1};
        vecs[6]  = '{A_DIV,               1'b0, 32'd0,          32'h1,      1'b1};
        vecs[7]  = '{A_DIV,               1'b1, 32'hABCD_1234,  32'h1,      1'b1};
        vecs[8]  = '{BASE + 32'hB,        1'b0, 32'd0,          32'h1234,   1'b1};
        vecs[9]  = '{A_ST,                1'b1, 32'hFFFF_FFFF,  32'h4,      1'b1};
        vecs[10] = '{A_ST,                1'b0, 32'd0,          32'h4,      1'b1};
        vecs[11] = '{BASE + 32'h10,       1'b0, 32'd0,          32'h0,      1'b0};
        vecs[12] = '{BASE + 32'hC,        1'b1, 32'h77,         32'h0,      1'b0};
        vecs[13] = '{BASE + 32'h5,        1'b0, 32'd0,          32'h4,      1'b1};

        rst  = 1'b1;
        addr = 32'd0;
        we   = 1'b0;
        wd   = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("resetTxd", 32'(txd), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_rd", i), rd, vecs[i].expRd);
            checkOutput($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].expSel));
        end
        @(negedge clk);
        we = 1'b0;
        busRead(A_DIV, st, s);
        checkOutput("divAfterOutsideWrite", st, 32'h1234);

        // Single byte, 4 clocks per bit.
        busWrite(A_DIV, 32'd4);
        monDiv = 4;
        startQ.delete();
        expQ.push_back(8'h55);
        busWrite(A_TX, 32'h55);
        waitIdle(200, idleCyc);
        checkOutput("frames55", 32'(startQ.size()), 32'd1);
        if (startQ.size() >= 1) checkOutput("busyLen55", 32'(idleCyc - startQ[0]), 32'd40);
        checkOutput("txdIdle55", 32'(txd), 32'd1);

        // Two bytes back to back at 2 clocks per bit.
        busWrite(A_DIV, 32'd2);
        monDiv = 2;
        startQ.delete();
        expQ.push_back(8'hA5);
        expQ.push_back(8'h3C);
        @(negedge clk);
        addr = A_TX;
        wd   = 32'hA5;
        we   = 1'b1;
        if (!FIFO_MODE) begin
            @(negedge clk);
            we = 1'b0;
        end
        @(negedge clk);
        wd = 32'h3C;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        busRead(A_ST, st, s);
        checkOutput("countDuringFrame", (st >> 8) & 32'hFF, 32'd1);
        checkOutput("busyDuringFrame", st & 32'h1, 32'd1);
        waitIdle(200, idleCyc);
        checkOutput("framesB2B", 32'(startQ.size()), 32'd2);
        if (startQ.size() >= 2) begin
            checkOutput("gapB2B", 32'(startQ[1] - startQ[0]), 32'd20);
            checkOutput("busyLenB2B", 32'(idleCyc - startQ[0]), 32'd40);
        end

        // Ten writes on consecutive cycles into a slow link: overflow and sticky-bit clear.
        busWrite(A_DIV, 32'd100);
        monDiv = 100;
        for (int i = 0; i < 10; i++) begin
            if (FIFO_MODE ? (i < 9) : (i == 0 || i == 2)) expQ.push_back(8'(8'h10 + i));
            @(negedge clk);
            addr = A_TX;
            wd   = 32'(8'h10 + i);
            we   = 1'b1;
        end
        @(negedge clk);
        we = 1'b0;
        busRead(A_ST, st, s);
        checkOutput("statusOverflow", st, FIFO_MODE ? 32'h0000_080B : 32'h0000_010B);
        busWrite(A_ST, 32'h8);
        busRead(A_ST, st, s);
        checkOutput("statusOvfCleared", st, FIFO_MODE ? 32'h0000_0803 : 32'h0000_0103);
        waitDrain(10_000);
        waitIdle(50, idleCyc);
        busRead(A_ST, st, s);
        checkOutput("statusDrained", st, 32'h4);

        // Asynchronous reset in the middle of a data bit with bytes still queued.
        busWrite(A_DIV, 32'd8);
        monDiv = 8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            addr = A_TX;
            wd   = 32'h00;
            we   = 1'b1;
        end
        @(negedge clk);
        we = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        checkOutput("txdLowMidFrame", 32'(txd), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("txdAsyncHigh", 32'(txd), 32'd1);
        @(negedge clk);
        addr = A_DIV;
        wd   = 32'd5;
        we   = 1'b1;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        busRead(A_ST, st, s);
        checkOutput("statusAfterReset", st, 32'h4);
        busRead(A_DIV, st, s);
        checkOutput("divAfterReset", st, DIVR);
        lowCnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (txd !== 1'b1) lowCnt++;
        end
        checkOutput("noFrameAfterReset", 32'(lowCnt), 32'd0);

        // DIV=0 is stored as 1: one clock per bit.
        busWrite(A_DIV, 32'd0);
        busRead(A_DIV, st, s);
        checkOutput("divZeroReadsOne", st, 32'h1);
        monDiv = 1;
        startQ.delete();
        expQ.push_back(8'hC3);
        busWrite(A_TX, 32'hC3);
        waitDrain(100);
        waitIdle(20, idleCyc);
        checkOutput("framesDiv1", 32'(startQ.size()), 32'd1);
        if (startQ.size() >= 1) checkOutput("busyLenDiv1", 32'(idleCyc - startQ[0]), 32'd10);
        busRead(BASE + 32'hC, st, s);
        checkOutput("outsideRd", st, 32'h0);
        checkOutput("outsideSel", 32'(s), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
